// File: rtl/ramb4_s4_fifo_ctrl_pkg.sv
// Shared constants and types for the RAMB4_S4 FIFO controller and its output buffer.
package fifo_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 4;
  localparam int OBUF_DEPTH = 2;
  localparam int PTR_W      = ADDR_W_DEF + 1;

  typedef logic [1:0] obuf_cnt_t;

  typedef enum logic [1:0] {
    OB_IDLE = 2'b00,
    OB_POP  = 2'b01,
    OB_PUSH = 2'b10,
    OB_BOTH = 2'b11
  } obuf_op_e;

  // Reads may only be issued while the buffer plus the read in flight still has a free slot.
  function automatic logic obuf_has_room(input obuf_cnt_t cnt, input logic inflight, input logic pop);
    logic [2:0] pending;
    pending = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    return (pending < 3'(OBUF_DEPTH));
  endfunction

endpackage

// File: rtl/ramb4_s4_fifo_ctrl_if.sv
// Write/read valid-ready stream bundle; the FIFO uses the slave view.
interface ramb4_s4_fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/ramb4_s4_fifo_ctrl_obuf.sv
// Two-entry output buffer that hides the RAM's registered read latency.
module ramb4_fifo_obuf
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLKA,
  input  logic              RSTB,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output obuf_cnt_t         cnt,
  output logic [DATA_W-1:0] head
);

  obuf_cnt_t         cnt_r;
  obuf_cnt_t         cnt_nxt_s;
  logic [DATA_W-1:0] head_r;
  logic [DATA_W-1:0] head_nxt_s;
  logic [DATA_W-1:0] tail_r;
  logic [DATA_W-1:0] tail_nxt_s;
  obuf_op_e          op_s;

  // Next-state of the two slots; head is forced to zero whenever the buffer drains.
  always_comb begin
    op_s       = obuf_op_e'({push, pop});
    cnt_nxt_s  = cnt_r;
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    case (op_s)
      OB_PUSH: begin
        if (cnt_r == 2'd0) begin
          head_nxt_s = push_data;
        end else begin
          tail_nxt_s = push_data;
        end
        cnt_nxt_s = cnt_r + 2'd1;
      end
      OB_POP: begin
        if (cnt_r == 2'd2) begin
          head_nxt_s = tail_r;
        end else begin
          head_nxt_s = {DATA_W{1'b0}};
        end
        cnt_nxt_s = cnt_r - 2'd1;
      end
      OB_BOTH: begin
        if (cnt_r == 2'd2) begin
          head_nxt_s = tail_r;
          tail_nxt_s = push_data;
        end else begin
          head_nxt_s = push_data;
        end
      end
      OB_IDLE: begin
        cnt_nxt_s = cnt_r;
      end
      default: begin
        cnt_nxt_s = cnt_r;
      end
    endcase
  end

  // Slot and count registers.
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      cnt_r  <= 2'd0;
      head_r <= {DATA_W{1'b0}};
      tail_r <= {DATA_W{1'b0}};
    end else begin
      cnt_r  <= cnt_nxt_s;
      head_r <= head_nxt_s;
      tail_r <= tail_nxt_s;
    end
  end

  assign cnt  = cnt_r;
  assign head = head_r;

endmodule

// File: rtl/ramb4_s4_fifo_ctrl.sv
// FIFO controller for a 1024x4 dual-port block RAM (port A write, port B read).
// Optional sticky ovf_err/udf_err outputs are built when FIFO_ERR_FLAGS_EN is defined.
module ramb4_s4_fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                CLKA,
  input  logic                RSTB,
  ramb4_s4_fifo_ctrl_if.slave bus,
  output logic [ADDR_W:0]     count,
  output logic [ADDR_W-1:0]   ram_addra,
  output logic [DATA_W-1:0]   ram_dia,
  output logic                ram_ena,
  output logic                ram_wea,
  output logic [ADDR_W-1:0]   ram_addrb,
  output logic                ram_enb,
  input  logic [DATA_W-1:0]   ram_dob
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                ovf_err,
  output logic                udf_err
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   occ_r;
  logic [ADDR_W:0]   ram_cnt_r;
  logic              inflight_r;
  obuf_cnt_t         obuf_cnt_s;
  logic [DATA_W-1:0] obuf_head_s;
  logic              wr_ready_s;
  logic              wr_acc_s;
  logic              rd_valid_s;
  logic              pop_s;
  logic              issue_s;

  // Handshake decode; ram_cnt_r is registered so a read never targets the slot written this edge.
  always_comb begin
    wr_ready_s = (occ_r < DEPTH_C) && !RSTB;
    wr_acc_s   = bus.wr_valid && wr_ready_s;
    rd_valid_s = (obuf_cnt_s != 2'd0);
    pop_s      = rd_valid_s && bus.rd_ready;
    issue_s    = (ram_cnt_r != {(ADDR_W+1){1'b0}}) && !RSTB &&
                 obuf_has_room(obuf_cnt_s, inflight_r, pop_s);
  end

  // Pointers, occupancy, RAM-resident count and the read-in-flight flag.
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      wr_ptr_r   <= {ADDR_W{1'b0}};
      rd_ptr_r   <= {ADDR_W{1'b0}};
      occ_r      <= {(ADDR_W+1){1'b0}};
      ram_cnt_r  <= {(ADDR_W+1){1'b0}};
      inflight_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      inflight_r <= issue_s;
      case ({wr_acc_s, pop_s})
        2'b10:   occ_r <= occ_r + CNT_ONE;
        2'b01:   occ_r <= occ_r - CNT_ONE;
        default: occ_r <= occ_r;
      endcase
      case ({wr_acc_s, issue_s})
        2'b10:   ram_cnt_r <= ram_cnt_r + CNT_ONE;
        2'b01:   ram_cnt_r <= ram_cnt_r - CNT_ONE;
        default: ram_cnt_r <= ram_cnt_r;
      endcase
    end
  end

  ramb4_fifo_obuf #(
    .DATA_W (DATA_W)
  ) u_obuf (
    .CLKA      (CLKA),
    .RSTB      (RSTB),
    .push      (inflight_r),
    .push_data (ram_dob),
    .pop       (pop_s),
    .cnt       (obuf_cnt_s),
    .head      (obuf_head_s)
  );

  assign bus.wr_ready = wr_ready_s;
  assign bus.rd_valid = rd_valid_s;
  assign bus.rd_data  = obuf_head_s;
  assign count        = occ_r;
  assign ram_ena      = wr_acc_s;
  assign ram_wea      = wr_acc_s;
  assign ram_addra    = wr_ptr_r;
  assign ram_dia      = bus.wr_data;
  assign ram_enb      = issue_s;
  assign ram_addrb    = rd_ptr_r;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_err_r;
  logic udf_err_r;

  // Sticky protocol-error flags, cleared only by reset.
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      ovf_err_r <= 1'b0;
      udf_err_r <= 1'b0;
    end else begin
      if (bus.wr_valid && !wr_ready_s) begin
        ovf_err_r <= 1'b1;
      end
      if (bus.rd_ready && !rd_valid_s) begin
        udf_err_r <= 1'b1;
      end
    end
  end

  assign ovf_err = ovf_err_r;
  assign udf_err = udf_err_r;
`endif

endmodule

// File: tb/tb_ramb4_s4_fifo_ctrl.sv
// Directed vector table plus scoreboarded sequences for ramb4_s4_fifo_ctrl with a behavioural RAM.
module tb_ramb4_s4_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int ADDR_W = ADDR_W_DEF;
  localparam int DATA_W = DATA_W_DEF;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              CLKA;
  logic              RSTB;
  logic [PTR_W-1:0]  count;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dia;
  logic              ram_ena;
  logic              ram_wea;
  logic [ADDR_W-1:0] ram_addrb;
  logic              ram_enb;
  logic [DATA_W-1:0] ram_dob;
`ifdef FIFO_ERR_FLAGS_EN
  logic              ovf_err;
  logic              udf_err;
`endif

  ramb4_s4_fifo_ctrl_if #(.DATA_W(DATA_W)) bus ();

  ramb4_s4_fifo_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .CLKA      (CLKA),
    .RSTB      (RSTB),
    .bus       (bus),
    .count     (count),
    .ram_addra (ram_addra),
    .ram_dia   (ram_dia),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addrb (ram_addrb),
    .ram_enb   (ram_enb),
    .ram_dob   (ram_dob)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .ovf_err   (ovf_err),
    .udf_err   (udf_err)
`endif
  );

  initial CLKA = 1'b0;
  always #5 CLKA = ~CLKA;

  logic [DATA_W-1:0] mem [DEPTH];

  always @(posedge CLKA) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  int checks = 0;
  int errors = 0;
  int m_occ  = 0;
  logic [DATA_W-1:0] q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // One clock of stimulus checked against the bench's own occupancy model and data queue.
  task automatic sb_cycle(input logic wv, input logic [DATA_W-1:0] wd, input logic rr, output logic popped);
    logic acc;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    #4;
    acc    = wv && (m_occ < DEPTH);
    popped = 1'b0;
    chk("count", int'(count), m_occ);
    chk("wr_ready", int'(bus.wr_ready), int'(m_occ < DEPTH));
    chk("ram_ena", int'(ram_ena), int'(acc));
    if (acc) chk("ram_dia", int'(ram_dia), int'(wd));
    if (m_occ == 0) chk("rd_valid_empty", int'(bus.rd_valid), 0);
    chk("obuf_cnt_le2", int'(dut.u_obuf.cnt_r <= 2'd2), 1);
    if (bus.rd_valid && rr) begin
      popped = 1'b1;
      if (q.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        chk("rd_data", int'(bus.rd_data), int'(q[0]));
        void'(q.pop_front());
      end
    end
    if (acc) q.push_back(wd);
    m_occ = m_occ + int'(acc) - int'(popped);
    @(posedge CLKA);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    logic p;
    for (int k = 0; k < max_cycles && q.size() != 0; k++) sb_cycle(1'b0, 4'h0, 1'b1, p);
    chk("drain_empty", q.size(), 0);
  endtask

  typedef struct {
    logic              rst;
    logic              wv;
    logic [DATA_W-1:0] wd;
    logic              rr;
    logic              e_rv;
    logic [DATA_W-1:0] e_rd;
    int                e_cnt;
    logic              e_wrdy;
    logic              e_ena;
    logic              e_enb;
  } vec_t;

  vec_t vt [15];

  initial begin
    logic p;
    int   pops;

    for (int i = 0; i < DEPTH; i++) mem[i] = 4'h0;
    RSTB = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 4'h0;
    bus.rd_ready = 1'b0;
    repeat (2) @(posedge CLKA);
    #1;

    //          rst   wv    wd    rr    rv    rd    cnt wrdy  ena   enb
    vt[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 0, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 0, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 1, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 4'h0, 0, 1'b1, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 4'h0, 1, 1'b1, 1'b1, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 4'hC, 1'b0, 1'b0, 4'h0, 2, 1'b1, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'hA, 3, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'hA, 3, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hA, 3, 1'b1, 1'b0, 1'b1};
    vt[12] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h5, 2, 1'b1, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hC, 1, 1'b1, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      RSTB         = vt[i].rst;
      bus.wr_valid = vt[i].wv;
      bus.wr_data  = vt[i].wd;
      bus.rd_ready = vt[i].rr;
      #4;
      chk($sformatf("v%0d_rd_valid", i), int'(bus.rd_valid), int'(vt[i].e_rv));
      chk($sformatf("v%0d_rd_data", i),  int'(bus.rd_data),  int'(vt[i].e_rd));
      chk($sformatf("v%0d_count", i),    int'(count),        vt[i].e_cnt);
      chk($sformatf("v%0d_wr_ready", i), int'(bus.wr_ready), int'(vt[i].e_wrdy));
      chk($sformatf("v%0d_ram_ena", i),  int'(ram_ena),      int'(vt[i].e_ena));
      chk($sformatf("v%0d_ram_enb", i),  int'(ram_enb),      int'(vt[i].e_enb));
      @(posedge CLKA);
      #1;
    end

    // Fill to full with no consumer, try one extra write, then pop while full.
    for (int i = 0; i < DEPTH; i++) sb_cycle(1'b1, 4'(i % 16), 1'b0, p);
    sb_cycle(1'b1, 4'hF, 1'b0, p);
    sb_cycle(1'b1, 4'hF, 1'b1, p);
    sb_cycle(1'b0, 4'h0, 1'b0, p);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_err_set", int'(ovf_err), 1);
`endif
    drain(DEPTH + 16);

    // Streaming at one entry per clock across several pointer wraps.
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      sb_cycle(1'b1, 4'((i * 7 + 3) % 16), 1'b1, p);
      pops += int'(p);
    end
    chk("stream_pops", pops, 2997);
    drain(16);

    // Random traffic with random backpressure.
    for (int i = 0; i < 2000; i++)
      sb_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), p);
    drain(DEPTH + 16);

    // Reset with five entries stored.
    for (int i = 0; i < 5; i++) sb_cycle(1'b1, 4'(i + 1), 1'b0, p);
    RSTB         = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 4'hE;
    bus.rd_ready = 1'b1;
    #4;
    chk("rst_wr_ready", int'(bus.wr_ready), 0);
    chk("rst_ram_ena", int'(ram_ena), 0);
    @(posedge CLKA);
    #1;
    RSTB = 1'b0;
    q.delete();
    m_occ = 0;
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_err_clr", int'(ovf_err), 0);
    chk("udf_err_clr", int'(udf_err), 0);
`endif
    sb_cycle(1'b0, 4'h0, 1'b0, p);
    chk("post_rst_rd_valid", int'(bus.rd_valid), 0);
    sb_cycle(1'b1, 4'h9, 1'b1, p);
    sb_cycle(1'b1, 4'h6, 1'b1, p);
    drain(16);
    for (int i = 0; i < 4; i++) sb_cycle(1'b0, 4'h0, 1'b1, p);
`ifdef FIFO_ERR_FLAGS_EN
    chk("udf_err_set", int'(udf_err), 1);
    chk("ovf_err_stays_clr", int'(ovf_err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ramb4_s4_fifo_ctrl.md
Name: ramb4_s4_fifo_ctrl

Overview:
Single-clock FIFO controller that drives a 1024x4 dual-port block RAM. Port A is write-only and port B is read-only.
- Upstream: valid/ready write interface.
- Downstream: valid/ready read interface with a 2-entry output buffer that absorbs the RAM's 1-cycle registered read latency.
- Used as the storage front end for byte/nibble streams between PicoBlaze-side logic and serial peripherals.

Parameters:
ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W entries
DATA_W, 4, entry width; must match RAM port width

Ports:
CLKA  in  1  clock for controller and both RAM ports
RSTB  in  1  reset
wr_valid  in  1  write request
wr_ready  out  1  space available
wr_data  in  DATA_W  write data
rd_valid  out  1  output data valid
rd_ready  in  1  consumer accepts
rd_data  out  DATA_W  output data
count  out  ADDR_W+1  occupancy, 0..DEPTH
ram_addra  out  ADDR_W  RAM port A address
ram_dia  out  DATA_W  RAM port A data
ram_ena  out  1  RAM port A enable
ram_wea  out  1  RAM port A write enable
ram_addrb  out  ADDR_W  RAM port B address
ram_enb  out  1  RAM port B enable
ram_dob  in  DATA_W  RAM port B registered read data

Behaviour:
- Reset: RSTB, synchronous, active-high; clock CLKA. On reset, wr_ptr, rd_ptr, occ, ram_cnt, inflight and obuf_cnt all clear to 0. Resulting outputs: rd_valid=0, rd_data=0, count=0, wr_ready=1.
- Reset mid-operation discards all stored data. Any RAM read in flight at reset is ignored.
- Write accept:
  - Accept when wr_valid && wr_ready. wr_ready = (occ < DEPTH) && !RSTB, registered-free.
  - On accept, the same cycle drives ram_ena=ram_wea=1, ram_addra=wr_ptr[ADDR_W-1:0], ram_dia=wr_data.
  - wr_ptr increments and wraps modulo DEPTH.
  - When not accepting, ram_ena=ram_wea=0.
- Occupancy:
  - occ increments on write accept and decrements on pop (rd_valid && rd_ready). Simultaneous accept and pop leaves it unchanged.
  - count = occ.
  - Occupancy never exceeds DEPTH, so a RAM slot is never overwritten before it has been read.
- RAM-resident count: ram_cnt is incremented at the write edge and decremented on read issue. Because it is registered, a read is never issued to an address written on the same edge, which avoids port collision.
- Read issue:
  - Issue when ram_cnt > 0 && (obuf_cnt + inflight - pop) < 2.
  - On issue: ram_enb=1, ram_addrb=rd_ptr; rd_ptr wraps modulo DEPTH; inflight<=1.
  - Otherwise ram_enb=0. The combinational rd_ready→ram_enb path is permitted.
- Capture: when inflight=1, ram_dob is pushed into the 2-entry obuf on the next edge.
- Output: rd_valid = obuf_cnt > 0; rd_data = head of obuf, 0 when empty.
- Latency: a write accepted at edge N produces rd_valid high after edge N+2 when the FIFO was empty. Sustained throughput is 1 entry/cycle with rd_ready held high.
- Ordering: strict FIFO order across pointer wrap.
- Full: wr_ready=0 at occ=DEPTH. A pop in that cycle does not raise wr_ready until the next cycle.
- Empty: rd_valid=0. rd_ready is ignored.

Optional Feature:
FIFO_ERR_FLAGS_EN: when defined, adds two outputs, ovf_err and udf_err, both 1 bit and sticky.
- ovf_err sets on wr_valid && !wr_ready.
- udf_err sets on rd_ready && !rd_valid.
- Both are cleared only by RSTB.
When the macro is undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Package fifo_ctrl_pkg: ADDR_W/DATA_W defaults, OBUF_DEPTH=2, and a pointer-width constant (ADDR_W+1).
- Sub-module ramb4_fifo_obuf: 2-entry output buffer with push/pop, obuf_cnt and head data. The top level holds the pointers, occ, ram_cnt and issue logic.

Test Plan:
- Reset then idle → wr_ready=1, rd_valid=0, count=0, ram_ena=ram_enb=0.
- Write 0x3 at edge N, rd_ready=1 → ram_enb pulses at N+1, rd_valid=1 with rd_data=0x3 after N+2, count returns to 0 after the pop.
- Fill 1024 entries with data=i%16, rd_ready=0 → wr_ready=0 and count=1024 after the last write. An extra wr_valid does not change the RAM contents.
- Continuous write and read of 3000 entries, rd_ready=1 → pointers wrap ≥2 times, output sequence matches input, 1 entry/cycle in steady state.
- Random rd_ready backpressure (50%) with random writes → scoreboard match, obuf_cnt never exceeds 2, no lost or duplicated entries.
- Assert RSTB mid-stream with 5 entries stored → next cycle count=0, rd_valid=0. Post-reset writes are read back with no stale data. With FIFO_ERR_FLAGS_EN defined, a write when full sets ovf_err and a read when empty sets udf_err.
